// File: rtl/instr_encoder.sv
// Encodes MIPS-style instruction requests into 32-bit words and streams them to instruction memory.
// Latency: one cycle from acceptance to the first mem_we_o, through a 2-entry FIFO.
// Backpressure: ready_o drops when the FIFO is full or memory capacity is committed; mem_ready_i stalls the head.

module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_vld,
    input  logic [WIDTH-1:0]           push_dat,
    input  logic                       pop_vld,
    output logic [WIDTH-1:0]           head_dat,
    output logic [$clog2(DEPTH):0]     occ
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push_vld) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ      <= '0;
        end else begin
            if (push_vld) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_vld)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_vld, pop_vld})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    assign head_dat = mem_q[rd_ptr_q];
endmodule

module instr_encoder #(
    parameter int ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [2:0]        kind_i,
    input  logic [4:0]        rs_i,
    input  logic [4:0]        rt_i,
    input  logic [4:0]        rd_i,
    input  logic [4:0]        shamt_i,
    input  logic [5:0]        funct_i,
    input  logic [15:0]       imm_i,
    input  logic [25:0]       target_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_data_o,
    input  logic              mem_ready_i,
    output logic [ADDR_W:0]   count_o,
    output logic              full_o,
    output logic              err_o
);
    localparam logic [ADDR_W+1:0] CAP = {2'b01, {ADDR_W{1'b0}}};

    logic [31:0]       enc_dat;
    logic [31:0]       head_dat;
    logic [1:0]        occ;
    logic              kind_ok;
    logic              accept;
    logic              push;
    logic              pop;
    logic [ADDR_W+1:0] fill;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W-1:0] addr_q;
    logic              err_q;

    always_comb begin
        enc_dat = '0;
        case (kind_i)
            3'd0:    enc_dat = {6'b000000, rs_i, rt_i, rd_i, shamt_i, funct_i};
            3'd1:    enc_dat = {6'b001000, rs_i, rt_i, imm_i};
            3'd2:    enc_dat = {6'b100011, rs_i, rt_i, imm_i};
            3'd3:    enc_dat = {6'b101011, rs_i, rt_i, imm_i};
            3'd4:    enc_dat = {6'b000100, rs_i, rt_i, imm_i};
            3'd5:    enc_dat = {6'b000010, target_i};
            default: enc_dat = '0;
        endcase
    end

    // Words already written plus words in flight must never exceed memory depth.
    assign fill    = {1'b0, count_q} + {{ADDR_W{1'b0}}, occ};
    assign ready_o = !rst_i && (occ != 2'd2) && (fill != CAP);
    assign kind_ok = (kind_i < 3'd6);
    assign accept  = valid_i && ready_o;
    assign push    = accept && kind_ok;
    assign pop     = mem_we_o && mem_ready_i;

    sync_fifo #(.WIDTH(32), .DEPTH(2)) u_fifo (
        .clk      (clk_i),
        .rst      (rst_i),
        .push_vld (push),
        .push_dat (enc_dat),
        .pop_vld  (pop),
        .head_dat (head_dat),
        .occ      (occ)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
            addr_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            if (pop) begin
                count_q <= count_q + 1'b1;
                if (!(&addr_q)) addr_q <= addr_q + 1'b1;
            end
            if (accept && !kind_ok) err_q <= 1'b1;
        end
    end

    assign mem_we_o   = (occ != 2'd0);
    assign mem_data_o = mem_we_o ? head_dat : 32'd0;
    assign mem_addr_o = addr_q;
    assign count_o    = count_q;
    assign full_o     = count_q[ADDR_W];
    assign err_o      = err_q;
endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: an 8-bit-address instance for the main checks and a
// 2-bit-address instance for capacity exhaustion, both scored against an encoding model.

module tb_instr_encoder;
    logic        clk = 1'b0;
    logic        rst, rst2, valid, valid2, mem_ready;
    logic [2:0]  kind;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] target;

    logic        ready, mem_we, full, err;
    logic [7:0]  mem_addr;
    logic [31:0] mem_data;
    logic [8:0]  count;

    logic        ready2, mem_we2, full2, err2;
    logic [1:0]  mem_addr2;
    logic [31:0] mem_data2;
    logic [2:0]  count2;

    int n_vec = 0;
    int n_err = 0;

    logic [39:0] q0[$];
    logic [39:0] q1[$];
    logic [7:0]  ea0, ea1;
    logic [31:0] wlog0 [256];
    logic [31:0] wlog1 [4];
    bit          acc, acc2;

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_W(8)) dut (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .ready_o(ready),
        .kind_i(kind), .rs_i(rs), .rt_i(rt), .rd_i(rd), .shamt_i(shamt),
        .funct_i(funct), .imm_i(imm), .target_i(target),
        .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_data_o(mem_data),
        .mem_ready_i(mem_ready), .count_o(count), .full_o(full), .err_o(err)
    );

    instr_encoder #(.ADDR_W(2)) dut2 (
        .clk_i(clk), .rst_i(rst2), .valid_i(valid2), .ready_o(ready2),
        .kind_i(kind), .rs_i(rs), .rt_i(rt), .rd_i(rd), .shamt_i(shamt),
        .funct_i(funct), .imm_i(imm), .target_i(target),
        .mem_we_o(mem_we2), .mem_addr_o(mem_addr2), .mem_data_o(mem_data2),
        .mem_ready_i(mem_ready), .count_o(count2), .full_o(full2), .err_o(err2)
    );

    function automatic logic [31:0] enc(input logic [2:0] k);
        case (k)
            3'd0:    return {6'h00, rs, rt, rd, shamt, funct};
            3'd1:    return {6'h08, rs, rt, imm};
            3'd2:    return {6'h23, rs, rt, imm};
            3'd3:    return {6'h2b, rs, rt, imm};
            3'd4:    return {6'h04, rs, rt, imm};
            3'd5:    return {6'h02, target};
            default: return 32'hxxxxxxxx;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: score writes and acceptances at the falling edge, then advance past the rising edge.
    task automatic cycle();
        logic [39:0] e;
        @(negedge clk);
        acc = 0;
        acc2 = 0;
        if (rst) begin
            q0.delete();
            ea0 = 0;
        end else begin
            if (mem_we && mem_ready) begin
                e = (q0.size() > 0) ? q0.pop_front() : 40'hxxxxxxxxxx;
                wlog0[mem_addr] = mem_data;
                chk("wr_addr", {56'd0, mem_addr}, {56'd0, e[39:32]});
                chk("wr_data", {32'd0, mem_data}, {32'd0, e[31:0]});
            end
            if (valid && ready) begin
                acc = 1;
                if (kind < 3'd6) begin
                    q0.push_back({ea0, enc(kind)});
                    ea0++;
                end
            end
        end
        if (rst2) begin
            q1.delete();
            ea1 = 0;
        end else begin
            if (mem_we2 && mem_ready) begin
                e = (q1.size() > 0) ? q1.pop_front() : 40'hxxxxxxxxxx;
                wlog1[mem_addr2] = mem_data2;
                chk("wr2_addr", {62'd0, mem_addr2}, {56'd0, e[39:32]});
                chk("wr2_data", {32'd0, mem_data2}, {32'd0, e[31:0]});
            end
            if (valid2 && ready2) begin
                acc2 = 1;
                if (kind < 3'd6) begin
                    q1.push_back({ea1, enc(kind)});
                    ea1++;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] k, input logic [4:0] a, input logic [4:0] b,
                         input logic [4:0] c, input logic [5:0] f, input logic [15:0] i,
                         input logic [25:0] t);
        kind = k; rs = a; rt = b; rd = c; shamt = 5'd0; funct = f; imm = i; target = t;
        valid = 1'b1;
    endtask

    task automatic wait_acc(input string tag, input int max);
        bit got = 0;
        for (int n = 0; n < max; n++) begin
            cycle();
            if (acc) begin
                got = 1;
                break;
            end
        end
        valid = 1'b0;
        chk(tag, {63'd0, got}, 64'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        chk("ready_in_reset", {63'd0, ready}, 64'd0);
        rst = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b1; rst2 = 1'b1; valid = 1'b0; valid2 = 1'b0; mem_ready = 1'b0;
        kind = 3'd0; rs = 0; rt = 0; rd = 0; shamt = 0; funct = 0; imm = 0; target = 0;
        ea0 = 0; ea1 = 0;

        // Reset state
        repeat (2) cycle();
        chk("ready_in_reset", {63'd0, ready}, 64'd0);
        rst = 1'b0; rst2 = 1'b0;
        #1;
        chk("rst_ready", {63'd0, ready}, 64'd1);
        chk("rst_we", {63'd0, mem_we}, 64'd0);
        chk("rst_addr", {56'd0, mem_addr}, 64'd0);
        chk("rst_data", {32'd0, mem_data}, 64'd0);
        chk("rst_count", {55'd0, count}, 64'd0);
        chk("rst_full", {63'd0, full}, 64'd0);
        chk("rst_err", {63'd0, err}, 64'd0);
        chk("rst2_ready", {63'd0, ready2}, 64'd1);

        // Single addi, one-cycle latency
        mem_ready = 1'b1;
        drive(3'd1, 5'd2, 5'd3, 5'd0, 6'd0, 16'h0005, 26'd0);
        wait_acc("acc_addi", 5);
        chk("addi_we", {63'd0, mem_we}, 64'd1);
        chk("addi_addr", {56'd0, mem_addr}, 64'd0);
        chk("addi_data", {32'd0, mem_data}, 64'h20430005);
        cycle();
        chk("addi_count", {55'd0, count}, 64'd1);
        chk("addi_we_after", {63'd0, mem_we}, 64'd0);

        // R, lw, j back to back
        do_reset();
        drive(3'd0, 5'd1, 5'd2, 5'd3, 6'h20, 16'd0, 26'd0);
        wait_acc("acc_r", 5);
        drive(3'd2, 5'd29, 5'd8, 5'd0, 6'd0, 16'd4, 26'd0);
        wait_acc("acc_lw", 5);
        drive(3'd5, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h10);
        wait_acc("acc_j", 5);
        repeat (4) cycle();
        chk("seq_w0", {32'd0, wlog0[0]}, 64'h00221820);
        chk("seq_w1", {32'd0, wlog0[1]}, 64'h8FA80004);
        chk("seq_w2", {32'd0, wlog0[2]}, 64'h08000010);
        chk("seq_count", {55'd0, count}, 64'd3);

        // Backpressure: FIFO fills, head holds, third request waits
        do_reset();
        mem_ready = 1'b0;
        drive(3'd0, 5'd1, 5'd2, 5'd3, 6'h20, 16'd0, 26'd0);
        wait_acc("bp_acc0", 5);
        drive(3'd2, 5'd29, 5'd8, 5'd0, 6'd0, 16'd4, 26'd0);
        wait_acc("bp_acc1", 5);
        drive(3'd5, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h10);
        for (int n = 0; n < 3; n++) begin
            chk("bp_ready", {63'd0, ready}, 64'd0);
            chk("bp_head", {32'd0, mem_data}, 64'h00221820);
            chk("bp_addr", {56'd0, mem_addr}, 64'd0);
            cycle();
            chk("bp_no_acc", {63'd0, acc}, 64'd0);
        end
        mem_ready = 1'b1;
        wait_acc("bp_acc2", 5);
        repeat (4) cycle();
        chk("bp_w0", {32'd0, wlog0[0]}, 64'h00221820);
        chk("bp_w1", {32'd0, wlog0[1]}, 64'h8FA80004);
        chk("bp_w2", {32'd0, wlog0[2]}, 64'h08000010);
        chk("bp_count", {55'd0, count}, 64'd3);

        // Invalid kind sets sticky err
        do_reset();
        drive(3'd7, 5'd1, 5'd1, 5'd1, 6'd0, 16'd0, 26'd0);
        wait_acc("inv_acc", 5);
        chk("inv_err", {63'd0, err}, 64'd1);
        chk("inv_we", {63'd0, mem_we}, 64'd0);
        chk("inv_count", {55'd0, count}, 64'd0);
        repeat (3) cycle();
        chk("inv_err_hold", {63'd0, err}, 64'd1);
        chk("inv_we_hold", {63'd0, mem_we}, 64'd0);
        drive(3'd4, 5'd4, 5'd5, 5'd0, 6'd0, 16'hFFFE, 26'd0);
        wait_acc("inv_then_beq", 5);
        cycle();
        chk("inv_beq_count", {55'd0, count}, 64'd1);
        chk("inv_err_sticky", {63'd0, err}, 64'd1);
        do_reset();
        chk("inv_err_cleared", {63'd0, err}, 64'd0);

        // Reset discards pending words
        mem_ready = 1'b0;
        drive(3'd3, 5'd6, 5'd7, 5'd0, 6'd0, 16'h0010, 26'd0);
        wait_acc("rq_acc0", 5);
        drive(3'd1, 5'd8, 5'd9, 5'd0, 6'd0, 16'h0020, 26'd0);
        wait_acc("rq_acc1", 5);
        chk("rq_we_pending", {63'd0, mem_we}, 64'd1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        #1;
        chk("rq_we", {63'd0, mem_we}, 64'd0);
        chk("rq_count", {55'd0, count}, 64'd0);
        chk("rq_data", {32'd0, mem_data}, 64'd0);
        chk("rq_ready", {63'd0, ready}, 64'd1);
        mem_ready = 1'b1;
        drive(3'd1, 5'd10, 5'd11, 5'd0, 6'd0, 16'h1234, 26'd0);
        wait_acc("rq_acc2", 5);
        chk("rq_addr", {56'd0, mem_addr}, 64'd0);
        chk("rq_new_data", {32'd0, mem_data}, 64'h214B1234);
        repeat (2) cycle();

        // Capacity exhaustion on the 4-word instance
        for (int n = 0; n < 4; n++) begin
            kind = 3'd1; rs = 5'd1; rt = 5'd2; imm = 16'(n + 1);
            valid2 = 1'b1;
            begin
                bit got = 0;
                for (int m = 0; m < 6; m++) begin
                    cycle();
                    if (acc2) begin
                        got = 1;
                        break;
                    end
                end
                valid2 = 1'b0;
                chk("full_acc", {63'd0, got}, 64'd1);
            end
        end
        repeat (4) cycle();
        chk("full_flag", {63'd0, full2}, 64'd1);
        chk("full_count", {61'd0, count2}, 64'd4);
        chk("full_ready", {63'd0, ready2}, 64'd0);
        chk("full_we", {63'd0, mem_we2}, 64'd0);
        chk("full_w0", {32'd0, wlog1[0]}, 64'h20220001);
        chk("full_w3", {32'd0, wlog1[3]}, 64'h20220004);
        kind = 3'd1; imm = 16'd5;
        valid2 = 1'b1;
        begin
            bit seen = 0;
            for (int m = 0; m < 8; m++) begin
                cycle();
                if (acc2) seen = 1;
            end
            valid2 = 1'b0;
            chk("full_fifth_refused", {63'd0, seen}, 64'd0);
        end
        chk("full_count_hold", {61'd0, count2}, 64'd4);
        chk("full_err2", {63'd0, err2}, 64'd0);

        chk("sb0_drained", 64'(q0.size()), 64'd0);
        chk("sb1_drained", 64'(q1.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
